// File: rtl/videomixer_layers.sv
`default_nettype none
// ============================================================================
//  Module   : videomixer_layers
//  Purpose  : N-layer RGB compositor. Samples all layers once per pixel period
//             on a 6x system clock, composes them by priority with colour-key
//             transparency, and optionally alpha-blends the topmost layer over
//             the composite beneath it with a vsync-stepped fade engine.
//  Options  : define VIDEOMIXER_FADE_EN to build the fade FSM, vsync edge
//             detector and blend multipliers. Without it the top layer is
//             simply selected over the composite and fadeLevel is fixed at MAX.
//  Revision : 1.0 - initial release
// ============================================================================
module videomixer_layers #(
    parameter int LAYERS       = 3,
    parameter int CW           = 6,
    parameter int PHASE_SAMPLE = 0,
    parameter int FADE_LOG2    = 4
) (
    input  logic                     sysClk,
    input  logic                     nReset,
    input  logic [2:0]               sysClkPhase,
    input  logic                     displayEnable,
    input  logic                     vsync,
    input  logic [LAYERS*3*CW-1:0]   rgb_in,
    input  logic [LAYERS-1:0]        layerEnable,
    input  logic [3*CW-1:0]          keyColour,
    input  logic                     fadeReq,
    input  logic                     fadeDir,
    output logic [3*CW-1:0]          rgb_out,
    output logic [FADE_LOG2:0]       fadeLevel,
    output logic                     fadeBusy
);

    localparam int             PW        = 3 * CW;
    localparam int             LW        = FADE_LOG2 + 1;
    localparam logic [LW-1:0]  MAX_LEVEL = LW'(2 ** FADE_LOG2);
    localparam logic [2:0]     PH_S      = 3'(PHASE_SAMPLE % 6);
    localparam logic [2:0]     PH_C      = 3'((PHASE_SAMPLE + 1) % 6);
    localparam logic [2:0]     PH_B      = 3'((PHASE_SAMPLE + 2) % 6);
    localparam logic [2:0]     PH_O      = 3'((PHASE_SAMPLE + 3) % 6);

    // Stage S: sampled inputs
    logic [LAYERS*PW-1:0] pix_s_q, pix_s_d;
    logic [LAYERS-1:0]    en_s_q,  en_s_d;
    logic                 de_s_q,  de_s_d;
    // Stage C: composed background and top layer
    logic [PW-1:0]        under_q, under_d;
    logic [PW-1:0]        top_q,   top_d;
    logic                 top_hit_q, top_hit_d;
    logic                 de_c_q,  de_c_d;
    // Stage B: blended pixel
    logic [PW-1:0]        blend_q, blend_d;
    logic                 de_b_q,  de_b_d;
    // Output register
    logic [PW-1:0]        rgb_out_q, rgb_out_d;
    // Composite of layers 0..LAYERS-2
    logic [PW-1:0]        acc;

    // Sample all layer inputs once per pixel period
    always_comb begin
        pix_s_d = pix_s_q;
        en_s_d  = en_s_q;
        de_s_d  = de_s_q;
        if (sysClkPhase == PH_S) begin
            pix_s_d = rgb_in;
            en_s_d  = layerEnable;
            de_s_d  = displayEnable;
        end
    end

    // Priority compose: higher layers override lower ones unless keyed out
    always_comb begin
        acc       = en_s_q[0] ? pix_s_q[0 +: PW] : '0;
        for (int i = 1; i < LAYERS - 1; i++) begin
            if (en_s_q[i] && (pix_s_q[i*PW +: PW] != keyColour)) begin
                acc = pix_s_q[i*PW +: PW];
            end
        end
        under_d   = under_q;
        top_d     = top_q;
        top_hit_d = top_hit_q;
        de_c_d    = de_c_q;
        if (sysClkPhase == PH_C) begin
            under_d   = acc;
            top_d     = pix_s_q[(LAYERS-1)*PW +: PW];
            top_hit_d = en_s_q[LAYERS-1] &&
                        (pix_s_q[(LAYERS-1)*PW +: PW] != keyColour);
            de_c_d    = de_s_q;
        end
    end

`ifdef VIDEOMIXER_FADE_EN
    localparam int BW = CW + FADE_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        FADE_OUT = 2'd2
    } fade_state_t;

    fade_state_t   state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic          vsync_q, vsync_d;
    logic          vsync_prev_q, vsync_prev_d;
    logic          vs_edge;
    logic          dir_tgt;
    logic [BW-1:0] prod_sum;

    assign vs_edge = vsync_q & ~vsync_prev_q;

    // Fade FSM: level steps only on vsync edges; a request re-targets the
    // direction evaluated against the level after any same-cycle step
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        vsync_d      = vsync_q;
        vsync_prev_d = vsync_prev_q;
        dir_tgt      = 1'b0;
        if (sysClkPhase < 3'd6) begin
            vsync_d      = vsync;
            vsync_prev_d = vsync_q;
            if (vs_edge) begin
                case (state_q)
                    FADE_IN:  level_d = level_q + LW'(1);
                    FADE_OUT: level_d = level_q - LW'(1);
                    default:  level_d = level_q;
                endcase
            end
            dir_tgt = fadeReq ? fadeDir : (state_q == FADE_IN);
            if (fadeReq || (state_q != IDLE)) begin
                if (dir_tgt && (level_d < MAX_LEVEL)) begin
                    state_d = FADE_IN;
                end else if (!dir_tgt && (level_d != '0)) begin
                    state_d = FADE_OUT;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // Per-component alpha blend of the top layer over the composite
    always_comb begin
        blend_d  = blend_q;
        de_b_d   = de_b_q;
        prod_sum = '0;
        if (sysClkPhase == PH_B) begin
            de_b_d = de_c_q;
            for (int k = 0; k < 3; k++) begin
                prod_sum = BW'(top_q[k*CW +: CW]) * BW'(level_q) +
                           BW'(under_q[k*CW +: CW]) * BW'(MAX_LEVEL - level_q);
                blend_d[k*CW +: CW] = top_hit_q ? CW'(prod_sum >> FADE_LOG2)
                                                : under_q[k*CW +: CW];
            end
        end
    end

    // Fade engine state registers
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            level_q      <= MAX_LEVEL;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    assign fadeLevel = level_q;
    assign fadeBusy  = (state_q != IDLE);
`else
    logic unused_fade_inputs;
    assign unused_fade_inputs = ^{fadeReq, fadeDir, vsync};

    // Without fading the top layer fully replaces the composite when visible
    always_comb begin
        blend_d = blend_q;
        de_b_d  = de_b_q;
        if (sysClkPhase == PH_B) begin
            blend_d = top_hit_q ? top_q : under_q;
            de_b_d  = de_c_q;
        end
    end

    assign fadeLevel = MAX_LEVEL;
    assign fadeBusy  = 1'b0;
`endif

    // Output register, blanked outside the active area
    always_comb begin
        rgb_out_d = rgb_out_q;
        if (sysClkPhase == PH_O) begin
            rgb_out_d = de_b_q ? blend_q : '0;
        end
    end

    // Pixel pipeline registers
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            pix_s_q   <= '0;
            en_s_q    <= '0;
            de_s_q    <= 1'b0;
            under_q   <= '0;
            top_q     <= '0;
            top_hit_q <= 1'b0;
            de_c_q    <= 1'b0;
            blend_q   <= '0;
            de_b_q    <= 1'b0;
            rgb_out_q <= '0;
        end else begin
            pix_s_q   <= pix_s_d;
            en_s_q    <= en_s_d;
            de_s_q    <= de_s_d;
            under_q   <= under_d;
            top_q     <= top_d;
            top_hit_q <= top_hit_d;
            de_c_q    <= de_c_d;
            blend_q   <= blend_d;
            de_b_q    <= de_b_d;
            rgb_out_q <= rgb_out_d;
        end
    end

    assign rgb_out = rgb_out_q;

endmodule
`default_nettype wire
